switch_input_ctrl: RTL and testbench

//  Front-end for the board slide switches: synchronises raw switches_pin, debounces each bit,

---
 rtl/io_pkg.sv | 13 +
 rtl/sw_debounce_bit.sv | 61 ++++++
 rtl/switch_input_ctrl.sv | 101 ++++++++++
 tb/tb_switch_input_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// io_pkg: register map shared by the switch input block and the MMIO decoder.
//   SW_REG_VALUE   word 0: debounced switch levels, zero-extended
//   SW_REG_CHANGED word 1: per-bit change flags, read-to-clear
//   SW_REG_STATUS  word 2: {31'b0, irq}
//   SW_REG_RSVD    word 3: reads as zero
package io_pkg;

  localparam logic [1:0] SW_REG_VALUE   = 2'd0;
  localparam logic [1:0] SW_REG_CHANGED = 2'd1;
  localparam logic [1:0] SW_REG_STATUS  = 2'd2;
  localparam logic [1:0] SW_REG_RSVD    = 2'd3;

endpackage

// File: rtl/sw_debounce_bit.sv
// sw_debounce_bit: one switch bit. Two-FF synchroniser, a sample history
// shifted on each tick, and a debounced level that only moves when the whole
// history agrees.
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset (clears sync chain, history, level)
//   pin_i    raw asynchronous switch level
//   tick_i   sample strobe from the shared prescaler
//   db_o     debounced level (registered)
//   db_d_o   debounced level that will be loaded on the next edge
module sw_debounce_bit #(
  parameter int unsigned STABLE_SAMPLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  input  logic tick_i,
  output logic db_o,
  output logic db_d_o
);

  logic                      sync1_q;
  logic                      sync2_q;
  logic [STABLE_SAMPLES-1:0] hist_q;
  logic [STABLE_SAMPLES-1:0] hist_d;
  logic                      db_q;
  logic                      db_d;

  // The new level is judged on the history as it will be after this tick,
  // so acceptance happens on the same edge as the final sample.
  always_comb begin
    hist_d = hist_q;
    db_d   = db_q;
    if (tick_i) begin
      hist_d = {hist_q[STABLE_SAMPLES-2:0], sync2_q};
      if (&hist_d) begin
        db_d = 1'b1;
      end else if (~|hist_d) begin
        db_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= '0;
      db_q    <= 1'b0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      hist_q  <= hist_d;
      db_q    <= db_d;
    end
  end

  assign db_o   = db_q;
  assign db_d_o = db_d;

endmodule

// File: rtl/switch_input_ctrl.sv
// switch_input_ctrl: slide-switch front end. Synchronises and debounces each
// switch bit, latches per-bit change flags and exposes them on a read-only
// MMIO port. irq is high while any change flag is set.
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   switches_pin  raw switch levels [WIDTH]
//   bus_rd        read strobe, one cycle per access
//   bus_addr      word offset (see io_pkg)
//   rd_data       registered read data, valid the cycle after bus_rd, else 0
//   sw_value      debounced switch levels [WIDTH]
//   irq           OR of the change flags
module switch_input_ctrl
  import io_pkg::*;
#(
  parameter int unsigned WIDTH          = 24,
  parameter int unsigned TICK_DIV       = 100000,
  parameter int unsigned STABLE_SAMPLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] switches_pin,
  input  logic             bus_rd,
  input  logic [1:0]       bus_addr,
  output logic [31:0]      rd_data,
  output logic [WIDTH-1:0] sw_value,
  output logic             irq
);

  localparam int unsigned PW = $clog2(TICK_DIV + 1);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]    presc_q;
  logic [PW-1:0]    presc_d;
  logic             tick;
  logic [WIDTH-1:0] db_val;
  logic [WIDTH-1:0] db_next;
  logic [WIDTH-1:0] set_mask;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] changed_q;
  logic [WIDTH-1:0] changed_d;
  logic [31:0]      rd_data_q;
  logic [31:0]      rd_data_d;

  assign tick = (presc_q == TICK_LAST);

  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit #(
      .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .pin_i  (switches_pin[i]),
      .tick_i (tick),
      .db_o   (db_val[i]),
      .db_d_o (db_next[i])
    );
  end

  // A read of the change register clears exactly what it returns; a bit that
  // debounces on that same edge is OR-ed back in so it is never lost.
  always_comb begin
    set_mask  = db_next ^ db_val;
    clr_mask  = (bus_rd && (bus_addr == SW_REG_CHANGED)) ? changed_q : '0;
    changed_d = (changed_q & ~clr_mask) | set_mask;
  end

  assign irq = |changed_q;

  always_comb begin
    rd_data_d = '0;
    if (bus_rd) begin
      case (bus_addr)
        SW_REG_VALUE:   rd_data_d[WIDTH-1:0] = db_val;
        SW_REG_CHANGED: rd_data_d[WIDTH-1:0] = changed_q;
        SW_REG_STATUS:  rd_data_d[0]         = irq;
        default:        rd_data_d            = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      changed_q <= '0;
      rd_data_q <= '0;
    end else begin
      presc_q   <= presc_d;
      changed_q <= changed_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign sw_value = db_val;

endmodule

// File: tb/tb_switch_input_ctrl.sv
module tb_switch_input_ctrl;

  localparam int unsigned W  = 24;
  localparam int unsigned TD = 4;
  localparam int unsigned S  = 3;

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic [W-1:0]  pins     = '0;
  logic          bus_rd   = 1'b0;
  logic [1:0]    bus_addr = 2'd0;
  logic [31:0]   rd_data;
  logic [W-1:0]  sw_value;
  logic          irq;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  string       nm_q[$];
  logic        mon_rd;

  switch_input_ctrl #(
    .WIDTH          (W),
    .TICK_DIV       (TD),
    .STABLE_SAMPLES (S)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .switches_pin (pins),
    .bus_rd       (bus_rd),
    .bus_addr     (bus_addr),
    .rd_data      (rd_data),
    .sw_value     (sw_value),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, exp);
    end
  endtask

  // Monitor: every edge that saw bus_rd yields one result to pop; every other
  // edge must leave rd_data at zero.
  always @(posedge clk) begin
    mon_rd = bus_rd;
    #1;
    if (mon_rd) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_unexpected: got=%h want=<no read queued>", rd_data);
      end else begin
        check(nm_q.pop_front(), rd_data, exp_q.pop_front());
      end
    end else begin
      check("rd_idle", rd_data, 32'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
    bus_rd   = 1'b1;
    bus_addr = a;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    tick();
    bus_rd   = 1'b0;
    bus_addr = 2'd0;
  endtask

  // Counts edges until the masked debounced value matches; latency must fall
  // inside [lo,hi].
  task automatic wait_sw(input logic [W-1:0] mask, input logic [W-1:0] val,
                         input int lo, input int hi, input string nm);
    int n;
    n = 0;
    while (((sw_value & mask) !== val) && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (n < lo || n > hi) begin
      bad++;
      $display("FAIL %s: latency got=%0d want=%0d..%0d (sw_value=%h)", nm, n, lo, hi, sw_value);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    int n_dev;

    // 1: reset with all pins high
    rst  = 1'b1;
    pins = '1;
    repeat (3) begin
      tick();
      check("t1_rst_sw", 32'(sw_value), 32'h0);
      check("t1_rst_irq", 32'(irq), 32'h0);
    end
    rst = 1'b0;
    wait_sw('1, '1, 11, 14, "t1_settle");
    check("t1_irq", 32'(irq), 32'h1);
    rd(2'd1, 32'h00FF_FFFF, "t1_changed");
    check("t1_irq_clr", 32'(irq), 32'h0);

    // 2: bring all low, then step bit0
    pins = '0;
    wait_sw('1, '0, 11, 14, "t2_all_low");
    rd(2'd1, 32'h00FF_FFFF, "t2_changed_low");
    check("t2_irq_idle", 32'(irq), 32'h0);
    pins = 24'h000001;
    wait_sw(24'h000001, 24'h000001, 11, 14, "t2_bit0");
    check("t2_irq_rise", 32'(irq), 32'h1);
    rd(2'd1, 32'h0000_0001, "t2_rd_changed");
    check("t2_irq_drop", 32'(irq), 32'h0);

    // 3: 6-cycle glitch on bit1
    n_dev = 0;
    pins = 24'h000003;
    repeat (6) begin
      tick();
      if (sw_value !== 24'h000001 || irq !== 1'b0) n_dev++;
    end
    pins = 24'h000001;
    repeat (30) begin
      tick();
      if (sw_value !== 24'h000001 || irq !== 1'b0) n_dev++;
    end
    check("t3_glitch_dev_cycles", 32'(n_dev), 32'h0);
    rd(2'd1, 32'h0, "t3_changed");

    // 4: bit2 debounces on the edge of a clearing read of bit0.
    // bit0 falls on a tick edge Ex; bit2 stepped right after Ex reaches sync
    // at Ex+2 and is sampled at Ex+4, Ex+8, Ex+12.
    pins = 24'h000000;
    wait_sw(24'h000001, 24'h000000, 11, 14, "t4_bit0_fall");
    pins = 24'h000004;
    repeat (11) tick();
    check("t4_bit2_pre", 32'(sw_value), 32'h0);
    check("t4_irq_pre", 32'(irq), 32'h1);
    rd(2'd1, 32'h0000_0001, "t4_collide_rd");
    check("t4_bit2_rise", 32'(sw_value), 32'h4);
    check("t4_irq_kept", 32'(irq), 32'h1);
    rd(2'd1, 32'h0000_0004, "t4_changed_kept");
    check("t4_irq_drop", 32'(irq), 32'h0);

    // 5: read mux, back-to-back
    pins = 24'hA5A5A5;
    wait_sw('1, 24'hA5A5A5, 11, 14, "t5_settle");
    check("t5_irq", 32'(irq), 32'h1);
    rd(2'd0, 32'h00A5_A5A5, "t5_value");
    rd(2'd2, 32'h0000_0001, "t5_status1");
    rd(2'd3, 32'h0000_0000, "t5_rsvd");
    rd(2'd1, 32'h00A5_A5A1, "t5_changed");
    rd(2'd2, 32'h0000_0000, "t5_status0");
    tick();

    // 6: reset two cycles into a bit3 step; read during reset returns 0
    pins = 24'hA5A5AD;
    repeat (2) tick();
    rst = 1'b1;
    rd(2'd0, 32'h0, "t6_rd_in_rst");
    tick();
    check("t6_rst_sw", 32'(sw_value), 32'h0);
    check("t6_rst_irq", 32'(irq), 32'h0);
    rst = 1'b0;
    wait_sw('1, 24'hA5A5AD, 11, 14, "t6_requal");
    rd(2'd1, 32'h00A5_A5AD, "t6_changed");

    repeat (3) tick();
    check("sb_empty", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
